eight_input_eval_arbiter: RTL and testbench

//   Shares one 8-input boolean evaluation unit among NUM_REQ requesters.

---
 rtl/eight_input_eval_arbiter_if.sv | 28 ++
 rtl/eight_input_eval_arbiter.sv | 80 ++++++++
 tb/tb_eight_input_eval_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/eight_input_eval_arbiter_if.sv
// eight_input_eval_arbiter_if: request/response bundle between requesters, consumer and the shared evaluator
//   req_valid/req_ready/req_data/req_mode : per-requester request handshake, 8-bit operand and timing mode
//   resp_valid/resp_ready/resp_y/resp_id  : tagged 1-bit result handshake
//   busy/done_cnt                         : status outputs of the evaluator
interface eight_input_eval_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int CNT_W = 16
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0] req_mode;
  logic resp_valid;
  logic resp_ready;
  logic resp_y;
  logic [ID_W-1:0] resp_id;
  logic busy;
  logic [CNT_W-1:0] done_cnt;
  modport master (
    output req_valid, req_data, req_mode, resp_ready,
    input req_ready, resp_valid, resp_y, resp_id, busy, done_cnt
  );
  modport slave (
    input req_valid, req_data, req_mode, resp_ready,
    output req_ready, resp_valid, resp_y, resp_id, busy, done_cnt
  );
endinterface

// File: rtl/eight_input_eval_arbiter.sv
// eight_input_eval_arbiter: round-robin sharing of one 8-input boolean evaluator among NUM_REQ requesters
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of eight_input_eval_arbiter_if (request handshake in, tagged result out, busy, done_cnt)
module eight_input_eval_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  eight_input_eval_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, win, id_q;
  logic [ID_W:0] idx;
  logic found, y_q;
  logic [7:0] operand, data_q;
  logic [CNT_W-1:0] cnt_q;

  // y = (((a&b)|(c^d)) & (~e|f)) ^ (g&~h), with a = bit 7 ... h = bit 0
  function automatic logic eval_fn(input logic [7:0] d);
    return (((d[7] & d[6]) | (d[5] ^ d[4])) & (~d[3] | d[2])) ^ (d[1] & ~d[0]);
  endfunction

  // Scan offsets from the far end back toward rr_ptr so the nearest pending requester wins last.
  always_comb begin
    win = rr_ptr;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      idx = (idx >= (ID_W + 1)'(NUM_REQ)) ? idx - (ID_W + 1)'(NUM_REQ) : idx;
      if (bus.req_valid[idx[ID_W-1:0]]) begin
        win = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign operand = bus.req_data[{win, 3'b000} +: 8];

  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (found ? (bus.req_mode[win] ? EVAL : HOLD) : IDLE) :
               (state == EVAL) ? HOLD :
               (bus.resp_ready ? IDLE : HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      data_q <= '0;
      y_q <= 1'b0;
      id_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        data_q <= operand;
        id_q <= win;
        rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        // Combinational mode evaluates straight into the result register at the accept edge.
        if (!bus.req_mode[win]) y_q <= eval_fn(operand);
      end
      if (state == EVAL) y_q <= eval_fn(data_q);
      if (state == HOLD && bus.resp_ready) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Gated by rst_n so no grant is offered while reset is held.
  assign bus.req_ready = (rst_n && state == IDLE && found) ? NUM_REQ'(1) << win : '0;
  assign bus.resp_valid = (state == HOLD);
  assign bus.busy = (state != IDLE);
  assign bus.resp_y = y_q;
  assign bus.resp_id = id_q;
  assign bus.done_cnt = cnt_q;
endmodule

// File: tb/tb_eight_input_eval_arbiter.sv
// tb_eight_input_eval_arbiter: scoreboard bench for the shared 8-input evaluator arbiter
module tb_eight_input_eval_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eight_input_eval_arbiter_if #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) bus ();
  eight_input_eval_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [3:0] valid = '0;
  logic [31:0] data = '0;
  logic [3:0] mode = '0;
  logic ready = 1'b0;
  assign bus.req_valid = valid;
  assign bus.req_data = data;
  assign bus.req_mode = mode;
  assign bus.resp_ready = ready;

  typedef struct {int id; bit y; int vcyc;} exp_t;
  exp_t q[$];
  int seen[$];
  int checks = 0, fails = 0, cyc = 0, issued = 0, completed = 0, release_cyc = -1;
  int model_ptr = 0, model_done = 0, pw;
  bit in_resp = 1'b0;
  logic [3:0] acc;
  exp_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ref_y(input logic [7:0] d);
    bit a = d[7], b = d[6], c = d[5], dd = d[4], ee = d[3], f = d[2], g = d[1], h = d[0];
    bit core = ((a && b) || (c != dd)) && (!ee || f);
    return core != (g && !h);
  endfunction

  always @(posedge clk) cyc++;

  // Predictor: whenever the reference evaluator is free, the round-robin winner is granted now.
  always @(negedge clk) begin
    if (!rst_n) model_ptr = 0;
    else if (issued == completed && cyc > release_cyc) begin
      chk("idle busy", bus.busy, 0);
      if (bus.req_valid != 0) begin
        pw = -1;
        for (int k = 0; k < 4; k++) if (pw < 0 && bus.req_valid[(model_ptr + k) % 4]) pw = (model_ptr + k) % 4;
        chk("grant", bus.req_ready, 1 << pw);
        q.push_back('{id: pw, y: ref_y(bus.req_data[8*pw +: 8]), vcyc: cyc + 1 + int'(bus.req_mode[pw])});
        issued++;
        model_ptr = (pw + 1) % 4;
      end else chk("no grant", bus.req_ready, 0);
    end else if (issued != completed) begin
      chk("ready blocked", bus.req_ready, 0);
      chk("busy", bus.busy, 1);
    end
  end

  // Monitor: compares every presented response against the head of the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      completed = issued;
      model_done = 0;
      in_resp = 1'b0;
      release_cyc = cyc;
    end else if (bus.resp_valid) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected resp: got id %0d y %0d expected none", bus.resp_id, bus.resp_y);
      end else begin
        e = q[0];
        if (!in_resp) chk("latency", cyc, e.vcyc);
        in_resp = 1'b1;
        chk("resp_id", bus.resp_id, e.id);
        chk("resp_y", bus.resp_y, e.y);
        if (bus.resp_ready) begin
          chk("done_cnt", bus.done_cnt, model_done & 16'hffff);
          model_done++;
          seen.push_back(e.id);
          void'(q.pop_front());
          completed++;
          release_cyc = cyc;
          in_resp = 1'b0;
        end
      end
    end
  end

  task automatic step(output logic [3:0] a);
    @(negedge clk);
    a = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [3:0] v, input int n, input bit hold);
    logic [3:0] a;
    int got = 0;
    valid = v;
    for (int t = 0; t < 100 * n && got < n; t++) begin
      step(a);
      for (int i = 0; i < 4; i++) if (a[i]) begin
        got++;
        if (!hold) valid[i] = 1'b0;
      end
    end
    valid = '0;
    chk("accept count", got, n);
  endtask

  task automatic drain();
    int t = 0;
    ready = 1'b1;
    while ((issued != completed || bus.resp_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", issued - completed, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", bus.req_ready, 0);
    chk("rst resp_valid", bus.resp_valid, 0);
    chk("rst done_cnt", bus.done_cnt, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst resp_y", bus.resp_y, 0);
    chk("rst resp_id", bus.resp_id, 0);
    valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    data[7:0] = 8'hC0;
    serve(4'b0001, 1, 1'b0);
    drain();
    chk("done after single", bus.done_cnt, 1);
    data[23:16] = 8'h02;
    mode[2] = 1'b1;
    serve(4'b0100, 1, 1'b0);
    drain();
    data[23:16] = 8'hC8;
    serve(4'b0100, 1, 1'b0);
    drain();
    chk("done after registered", bus.done_cnt, 3);
    ready = 1'b0;
    data[15:8] = 8'hFF;
    mode[1] = 1'b0;
    serve(4'b0010, 1, 1'b0);
    data[31:24] = 8'h02;
    mode[3] = 1'b0;
    valid[3] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp resp_valid", bus.resp_valid, 1);
      chk("bp req_ready", bus.req_ready, 0);
      chk("bp done_cnt", bus.done_cnt, 3);
      chk("bp resp_id", bus.resp_id, 1);
      chk("bp resp_y", bus.resp_y, 1);
    end
    @(posedge clk);
    #1 ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp next grant", bus.req_ready, 4'b1000);
    chk("bp done after", bus.done_cnt, 4);
    @(posedge clk);
    #1 valid = '0;
    drain();
    data[23:16] = 8'h00;
    mode[2] = 1'b1;
    serve(4'b0100, 1, 1'b0);
    valid = 4'hF;
    #1 rst_n = 1'b0;
    #1;
    chk("async resp_valid", bus.resp_valid, 0);
    chk("async busy", bus.busy, 0);
    chk("async req_ready", bus.req_ready, 0);
    chk("async done_cnt", bus.done_cnt, 0);
    chk("async resp_y", bus.resp_y, 0);
    valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    seen.delete();
    serve(4'b1010, 2, 1'b0);
    drain();
    chk("post-reset count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("post-reset first id", seen[0], 1);
      chk("post-reset second id", seen[1], 3);
    end
    chk("post-reset done_cnt", bus.done_cnt, 2);
    data = 32'hFFFF_FFFF;
    mode = '0;
    seen.delete();
    serve(4'hF, 5, 1'b1);
    drain();
    chk("rr count", seen.size(), 5);
    for (int i = 0; i < seen.size() && i < 5; i++) chk("rr id", seen[i], i % 4);
    for (int n = 0; n < 400; n++) begin
      step(acc);
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) valid[i] = 1'b0;
        else if (!valid[i] && $urandom_range(0, 3) == 0) begin
          valid[i] = 1'b1;
          data[8*i +: 8] = 8'($urandom);
          mode[i] = 1'($urandom);
        end
      end
      ready = ($urandom_range(0, 3) != 0);
    end
    valid = '0;
    drain();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
